// File: rtl/shift_seq_ctrl_if.sv
// Request/response bus between the execute-stage issue logic and the
// shift sequencer, plus the sequencer-to-write-back result path.
//
// Handshake semantics (both channels): a transfer happens on a rising
// clock edge where valid && ready are both high. The producer holds valid
// and its payload stable until that edge. The consumer may drive ready
// independently of valid.
interface shift_seq_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_shamt;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  // Issue side: sends requests and consumes responses.
  modport master (
    output req_valid, req_op, req_shamt, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_op, req_shamt, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer around one 32-bit logical-left shifter.
// Right shifts use bit reversal around the left shifter; SRA and the
// rotates with a non-zero amount take a second pass through the same
// shifter to build the sign fill or the wrapped-around bits.

// Combinational logical-left barrel shifter from the datapath.
module Shifter (
  input  logic [31:0] target,
  input  logic [4:0]  shamt,
  output logic [31:0] result
);
  assign result = target << shamt;
endmodule

module shift_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  shift_seq_ctrl_if.slave  bus,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [2:0] OP_SLL  = 3'd0;
  localparam logic [2:0] OP_SRL  = 3'd1;
  localparam logic [2:0] OP_SRA  = 3'd2;
  localparam logic [2:0] OP_ROTL = 3'd3;
  localparam logic [2:0] OP_ROTR = 3'd4;

  function automatic logic [31:0] rev32(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[i] = x[31-i];
    return y;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;
  logic [4:0]       r_shamt;
  logic [31:0]      r_data;
  logic [31:0]      r_acc;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_err;
  logic [CNT_W-1:0] r_done_cnt;

  logic        w_accept;
  logic        w_req_legal;
  logic        w_two_pass;
  logic        w_pass1_direct;
  logic [4:0]  w_shamt_m;
  logic [31:0] w_sh_target;
  logic [4:0]  w_sh_shamt;
  logic [31:0] w_shl;
  logic [31:0] w_pass1_val;
  logic [31:0] w_pass2_val;

  assign bus.req_ready  = (r_state == IDLE) && !rst;
  assign w_accept       = bus.req_valid && bus.req_ready;
  assign w_req_legal    = (bus.req_op <= OP_ROTR);
  assign w_two_pass     = ((r_op == OP_SRA) || (r_op == OP_ROTL) || (r_op == OP_ROTR))
                          && (r_shamt != 5'd0);
  // SLL and ROTL shift left directly; SRL, SRA and ROTR go through reversal.
  assign w_pass1_direct = (r_op == OP_SLL) || (r_op == OP_ROTL);
  // Complementary amount 32-n for the wrap-around part of a rotate.
  assign w_shamt_m      = (~r_shamt) + 5'd1;

  Shifter u_shifter (
    .target (w_sh_target),
    .shamt  (w_sh_shamt),
    .result (w_shl)
  );

  // Shifter operand muxes; held at zero outside the two shift passes.
  always_comb begin
    w_sh_target = 32'd0;
    w_sh_shamt  = 5'd0;
    case (r_state)
      PASS1: begin
        w_sh_target = w_pass1_direct ? r_data : rev32(r_data);
        w_sh_shamt  = r_shamt;
      end
      PASS2: begin
        case (r_op)
          OP_SRA: begin
            w_sh_target = 32'hFFFF_FFFF;
            w_sh_shamt  = r_shamt;
          end
          OP_ROTL: begin
            w_sh_target = rev32(r_data);
            w_sh_shamt  = w_shamt_m;
          end
          default: begin
            w_sh_target = r_data;
            w_sh_shamt  = w_shamt_m;
          end
        endcase
      end
      default: ;
    endcase
  end

  // Pass results: pass 1 is the plain shift, pass 2 merges sign fill or wrap bits.
  always_comb begin
    w_pass1_val = w_pass1_direct ? w_shl : rev32(w_shl);
    w_pass2_val = r_acc;
    case (r_op)
      OP_SRA:  w_pass2_val = r_data[31] ? (r_acc | ~rev32(w_shl)) : r_acc;
      OP_ROTL: w_pass2_val = r_acc | rev32(w_shl);
      OP_ROTR: w_pass2_val = r_acc | w_shl;
      default: w_pass2_val = r_acc;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; illegal ops skip the shifter and go straight to DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = w_req_legal ? PASS1 : DONE;
      PASS1:   w_state_nxt = w_two_pass ? PASS2 : DONE;
      PASS2:   w_state_nxt = DONE;
      DONE:    if (bus.rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request capture, accumulator, response registers and completion count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= 3'd0;
      r_shamt    <= 5'd0;
      r_data     <= 32'd0;
      r_acc      <= 32'd0;
      r_rsp_data <= 32'd0;
      r_rsp_err  <= 1'b0;
      r_done_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= bus.req_op;
            r_shamt <= bus.req_shamt;
            r_data  <= bus.req_data;
            if (!w_req_legal) begin
              r_rsp_data <= 32'd0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        PASS1: begin
          r_acc <= w_pass1_val;
          if (!w_two_pass) begin
            r_rsp_data <= w_pass1_val;
            r_rsp_err  <= 1'b0;
          end
        end
        PASS2: begin
          r_rsp_data <= w_pass2_val;
          r_rsp_err  <= 1'b0;
        end
        DONE: begin
          if (bus.rsp_ready) r_done_cnt <= r_done_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = (r_state == DONE);
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign busy          = (r_state != IDLE);
  assign done_cnt      = r_done_cnt;
  assign o_dbg_state   = r_state;

endmodule
